// File: rtl/addr_sequencer.sv
// T-state sequencer for the 6502 address/index datapath: steps RST/T0..T4 per
// addressing mode and decodes the per-cycle bus and register strobes from (state, mode_q).
module addr_sequencer #(
   parameter int RESET_CYCLES = 2
) (
   input  logic       ph0,
   input  logic       reset,
   input  logic       rdy,
   input  logic [2:0] mode,
   input  logic       alu_carry,
   output logic [2:0] t_state,
   output logic       sync,
   output logic       last_cycle,
   output logic       pc_addr,
   output logic       pc_inc,
   output logic       adl_abl,
   output logic       adh_abh,
   output logic       dl_db,
   output logic       dl_adl,
   output logic       dl_adh,
   output logic       add_adl,
   output logic       x_sb,
   output logic       y_sb,
   output logic       alu_add,
   output logic       zero_adh,
   output logic       adh_inc
);

   typedef enum logic [2:0] {
      T0  = 3'd0,
      T1  = 3'd1,
      T2  = 3'd2,
      T3  = 3'd3,
      T4  = 3'd4,
      RST = 3'd7
   } state_t;

   localparam logic [2:0] M_IMP  = 3'd0;
   localparam logic [2:0] M_IMM  = 3'd1;
   localparam logic [2:0] M_ZP   = 3'd2;
   localparam logic [2:0] M_ZPX  = 3'd3;
   localparam logic [2:0] M_ABS  = 3'd4;
   localparam logic [2:0] M_ABSX = 3'd5;
   localparam logic [2:0] M_ABSY = 3'd6;
   localparam logic [2:0] RST_LAST = 3'(RESET_CYCLES - 1);

   state_t     state;
   logic [2:0] rst_cnt;
   logic [2:0] mode_q;
   logic       is_two_cycle;
   logic       is_indexed_abs;

   // Mode 7 behaves exactly like implied addressing
   assign is_two_cycle   = (mode_q == M_IMP) || (mode_q == M_IMM) || (mode_q == 3'd7);
   assign is_indexed_abs = (mode_q == M_ABSX) || (mode_q == M_ABSY);

   always_ff @(posedge ph0 or posedge reset) begin
      if (reset) begin
         state   <= RST;
         rst_cnt <= 3'd0;
         mode_q  <= 3'd0;
      end else if (rdy) begin
         case (state)
            RST: begin
               if (rst_cnt == RST_LAST) begin
                  state   <= T0;
                  rst_cnt <= 3'd0;
               end else begin
                  rst_cnt <= rst_cnt + 3'd1;
               end
            end
            T0: begin
               mode_q <= mode;
               state  <= T1;
            end
            T1:      state <= is_two_cycle ? T0 : T2;
            T2:      state <= (mode_q == M_ZP) ? T0 : T3;
            // Page crossing on indexed absolute needs the extra ABH fix-up cycle
            T3:      state <= (is_indexed_abs && alu_carry) ? T4 : T0;
            T4:      state <= T0;
            default: state <= T0;
         endcase
      end
   end

   always_comb begin
      t_state    = state;
      sync       = 1'b0;
      last_cycle = 1'b0;
      pc_addr    = 1'b0;
      pc_inc     = 1'b0;
      adl_abl    = 1'b0;
      adh_abh    = 1'b0;
      dl_db      = 1'b0;
      dl_adl     = 1'b0;
      dl_adh     = 1'b0;
      add_adl    = 1'b0;
      x_sb       = 1'b0;
      y_sb       = 1'b0;
      alu_add    = 1'b0;
      zero_adh   = 1'b0;
      adh_inc    = 1'b0;
      case (state)
         T0: begin
            sync    = 1'b1;
            pc_addr = 1'b1;
            adl_abl = 1'b1;
            adh_abh = 1'b1;
            pc_inc  = 1'b1;
         end
         T1: begin
            pc_addr    = 1'b1;
            adl_abl    = 1'b1;
            adh_abh    = 1'b1;
            pc_inc     = !((mode_q == M_IMP) || (mode_q == 3'd7));
            dl_db      = (mode_q == M_IMM);
            last_cycle = is_two_cycle;
         end
         T2: begin
            if (mode_q == M_ZP) begin
               dl_adl     = 1'b1;
               adl_abl    = 1'b1;
               zero_adh   = 1'b1;
               adh_abh    = 1'b1;
               last_cycle = 1'b1;
            end else if (mode_q == M_ZPX) begin
               dl_db   = 1'b1;
               x_sb    = 1'b1;
               alu_add = 1'b1;
            end else if ((mode_q == M_ABS) || is_indexed_abs) begin
               // Low address byte goes through the adder; SB stays idle (0) for plain ABS
               pc_addr = 1'b1;
               adl_abl = 1'b1;
               adh_abh = 1'b1;
               pc_inc  = 1'b1;
               dl_db   = 1'b1;
               alu_add = 1'b1;
               x_sb    = (mode_q == M_ABSX);
               y_sb    = (mode_q == M_ABSY);
            end
         end
         T3: begin
            if (mode_q == M_ZPX) begin
               add_adl    = 1'b1;
               adl_abl    = 1'b1;
               zero_adh   = 1'b1;
               adh_abh    = 1'b1;
               last_cycle = 1'b1;
            end else if ((mode_q == M_ABS) || is_indexed_abs) begin
               add_adl    = 1'b1;
               adl_abl    = 1'b1;
               dl_adh     = 1'b1;
               adh_abh    = 1'b1;
               last_cycle = is_indexed_abs ? !alu_carry : 1'b1;
            end
         end
         T4: begin
            if (is_indexed_abs) begin
               adh_inc    = 1'b1;
               adh_abh    = 1'b1;
               last_cycle = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule
